// File: rtl/wbcarbiter_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter: FSM states and the
// rotating priority pick used to choose the next bus owner.
package wbcarbiter_pkg;

  localparam int MAX_NM = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  // One-hot winner: first set bit of req scanning last+1, last+2, ... mod nm.
  function automatic logic [MAX_NM-1:0] rr_pick(input logic [MAX_NM-1:0] req,
                                                input logic [2:0]        last,
                                                input int                nm);
    logic [MAX_NM-1:0] pick;
    logic              found;
    int                idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_NM; i++) begin
      if (i <= nm) begin
        idx = (int'(last) + i) % nm;
        if (!found && req[idx]) begin
          pick[idx] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/wbcarbiter_wdog.sv
// Bus watchdog: counts strobe cycles left unanswered and raises a one-cycle
// tmo in the TIMEOUT-th waiting cycle. TIMEOUT=0 removes the counter entirely.
module wbcwatchdog
  import wbcarbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_stb,
  input  logic i_ack,
  input  logic i_err,
  input  logic i_clear,
  output logic o_tmo
);

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int              WW    = $clog2(TIMEOUT + 1);
      localparam logic [WW-1:0]   LIMIT = WW'(TIMEOUT - 1);
      localparam logic [WW-1:0]   WMAX  = '1;

      logic [WW-1:0] wdog_q, wdog_d;
      logic          waiting;

      always_comb begin
        waiting = i_stb & ~i_ack & ~i_err;
        o_tmo   = waiting & (wdog_q == LIMIT);
        wdog_d  = wdog_q;
        if (i_clear || !waiting || o_tmo) begin
          wdog_d = '0;
        end else if (wdog_q != WMAX) begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          wdog_q <= '0;
        end else begin
          wdog_q <= wdog_d;
        end
      end
    end else begin : g_nowdog
      logic unused_wdog_inputs;
      assign unused_wdog_inputs = ^{i_clk, i_reset, i_stb, i_ack, i_err, i_clear};
      assign o_tmo = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/wbcarbiter.sv
// Round-robin arbiter for NM Wishbone classic masters onto one master port.
// The grant is held for the owner's whole CYC; unanswered strobes end in ERR.
module wbcarbiter
  import wbcarbiter_pkg::*;
#(
  parameter int NM      = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NM-1:0]     i_mcyc,
  input  logic [NM-1:0]     i_mstb,
  input  logic [NM-1:0]     i_mwe,
  input  logic [NM*AW-1:0]  i_maddr,
  input  logic [NM*DW-1:0]  i_mdata,
  input  logic [NM*SW-1:0]  i_msel,
  output logic [NM-1:0]     o_mack,
  output logic [DW-1:0]     o_mdata,
  output logic [NM-1:0]     o_merr,
  output logic              o_scyc,
  output logic              o_sstb,
  output logic              o_swe,
  output logic [AW-1:0]     o_saddr,
  output logic [DW-1:0]     o_sdata,
  output logic [SW-1:0]     o_ssel,
  input  logic              i_sack,
  input  logic [DW-1:0]     i_sdata,
  input  logic              i_serr
);

  localparam int LW = (NM > 1) ? $clog2(NM) : 1;

  arb_state_t        state_q, state_d;
  logic [NM-1:0]     grant_q, grant_d;
  logic [LW-1:0]     last_q, last_d;
  logic [MAX_NM-1:0] pick;
  logic [LW-1:0]     win_idx;
  logic              tmo;
  logic              grant_change;

  always_comb begin
    pick    = rr_pick(MAX_NM'(i_mcyc), 3'(last_q), NM);
    win_idx = '0;
    for (int k = 0; k < MAX_NM; k++) begin
      if (pick[k]) begin
        win_idx = LW'(k);
      end
    end
  end

  // Releasing always passes through IDLE, which gives the mandatory idle
  // cycle between owners and makes the next scan start past the old owner.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (|i_mcyc) begin
          grant_d = pick[NM-1:0];
          last_d  = win_idx;
          state_d = ARB_OWNED;
        end
      end
      ARB_OWNED: begin
        if (!(|(grant_q & i_mcyc))) begin
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= LW'(NM - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    o_scyc  = |(grant_q & i_mcyc);
    o_sstb  = |(grant_q & i_mstb);
    o_swe   = |(grant_q & i_mwe);
    o_saddr = '0;
    o_sdata = '0;
    o_ssel  = '0;
    for (int k = 0; k < NM; k++) begin
      if (grant_q[k]) begin
        o_saddr = o_saddr | i_maddr[k*AW +: AW];
        o_sdata = o_sdata | i_mdata[k*DW +: DW];
        o_ssel  = o_ssel  | i_msel[k*SW +: SW];
      end
    end
  end

  assign grant_change = (grant_d != grant_q);

  wbcwatchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_stb   (o_sstb),
    .i_ack   (i_sack),
    .i_err   (i_serr),
    .i_clear (grant_change),
    .o_tmo   (tmo)
  );

  // A timeout masks a coincident ACK so the master sees exactly one response.
  assign o_mack  = grant_q & {NM{i_sack & ~tmo}};
  assign o_merr  = grant_q & {NM{i_serr | tmo}};
  assign o_mdata = i_sdata;

endmodule

// File: tb/tb_wbcarbiter.sv
// Randomised bench for wbcarbiter against a cycle-level ownership/timeout model.
module tb_wbcarbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;
  localparam int VW = 3 + AW + DW + SW + 2 * NM + DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM-1:0]    mcyc, mstb, mwe;
  logic [AW-1:0]    maddr [NM];
  logic [DW-1:0]    mdat  [NM];
  logic [SW-1:0]    msel  [NM];
  logic [NM*AW-1:0] maddr_flat;
  logic [NM*DW-1:0] mdat_flat;
  logic [NM*SW-1:0] msel_flat;
  logic             sack, serr;
  logic [DW-1:0]    sdata;

  logic [NM-1:0] o_mack, o_merr;
  logic [DW-1:0] o_mdata, o_sdata;
  logic          o_scyc, o_sstb, o_swe;
  logic [AW-1:0] o_saddr;
  logic [SW-1:0] o_ssel;

  generate
    for (genvar gi = 0; gi < NM; gi++) begin : g_flat
      assign maddr_flat[gi*AW +: AW] = maddr[gi];
      assign mdat_flat[gi*DW +: DW]  = mdat[gi];
      assign msel_flat[gi*SW +: SW]  = msel[gi];
    end
  endgenerate

  wbcarbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_mcyc(mcyc), .i_mstb(mstb), .i_mwe(mwe),
    .i_maddr(maddr_flat), .i_mdata(mdat_flat), .i_msel(msel_flat),
    .o_mack(o_mack), .o_mdata(o_mdata), .o_merr(o_merr),
    .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
    .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
    .i_sack(sack), .i_sdata(sdata), .i_serr(serr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus, who owned it last, how long STB waited.
  int m_owner = -1;
  int m_last  = NM - 1;
  int m_wdog  = 0;

  logic          e_scyc, e_sstb, e_swe, e_wait, e_tmo;
  logic [AW-1:0] e_saddr;
  logic [DW-1:0] e_sdata;
  logic [SW-1:0] e_ssel;
  logic [NM-1:0] e_mack, e_merr;

  always_comb begin
    e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0;
    e_saddr = '0; e_sdata = '0; e_ssel = '0;
    e_mack = '0; e_merr = '0;
    if (m_owner >= 0) begin
      e_scyc  = mcyc[m_owner];
      e_sstb  = mstb[m_owner];
      e_swe   = mwe[m_owner];
      e_saddr = maddr[m_owner];
      e_sdata = mdat[m_owner];
      e_ssel  = msel[m_owner];
    end
    e_wait = e_sstb && !sack && !serr;
    e_tmo  = e_wait && (m_wdog == TO - 1);
    if (m_owner >= 0) begin
      e_mack[m_owner] = sack && !e_tmo;
      e_merr[m_owner] = serr || e_tmo;
    end
  end

  always @(posedge clk) begin
    int n_owner, n_last, n_wdog;
    n_owner = m_owner;
    n_last  = m_last;
    n_wdog  = (e_wait && !e_tmo) ? m_wdog + 1 : 0;
    if (rst) begin
      n_owner = -1;
      n_last  = NM - 1;
      n_wdog  = 0;
    end else if (m_owner >= 0) begin
      if (!mcyc[m_owner]) begin
        n_owner = -1;
        n_wdog  = 0;
      end
    end else begin
      for (int i = 1; i <= NM; i++) begin
        if (n_owner < 0 && mcyc[(m_last + i) % NM]) n_owner = (m_last + i) % NM;
      end
      if (n_owner >= 0) begin
        n_last = n_owner;
        n_wdog = 0;
      end
    end
    m_owner <= n_owner;
    m_last  <= n_last;
    m_wdog  <= n_wdog;
  end

  wire [VW-1:0] act_vec = {o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel, o_mack, o_merr, o_mdata};
  wire [VW-1:0] exp_vec = {e_scyc, e_sstb, e_swe, e_saddr, e_sdata, e_ssel, e_mack, e_merr, sdata};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    mcyc = '0; mstb = '0; mwe = '0; sack = 1'b0; serr = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic load_master(input int k);
    maddr[k] = {8'(k), 24'($urandom)};
    mdat[k]  = $urandom;
    msel[k]  = 4'($urandom);
    mwe[k]   = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; mcyc = '0; mstb = '0; mwe = '0; sack = 1'b0; serr = 1'b0;
    sdata = $urandom;
    for (int k = 0; k < NM; k++) load_master(k);
    tick(); tick();
    @(negedge clk);
    total++;
    if ({o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel, o_mack, o_merr} !== '0) begin
      bad++;
      $display("FAIL reset_zero act=%h required all zero", act_vec);
    end
    total++;
    if (act_vec !== exp_vec) begin
      bad++;
      $display("FAIL reset_model act=%h exp=%h", act_vec, exp_vec);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    maddr[0] = 32'h10; mdat[0] = $urandom; msel[0] = 4'hf;
    mwe[0] = 1'b1; mcyc[0] = 1'b1; mstb[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin sack = 1'b1; sdata = $urandom; end
      if (c == 3) begin sack = 1'b0; mcyc = '0; mstb = '0; mwe = '0; end
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL single_model c=%0d act=%h exp=%h", c, act_vec, exp_vec);
      end
      if (c == 0) begin
        total++;
        if (o_scyc !== 1'b0) begin
          bad++;
          $display("FAIL single_latency scyc=%b required 0", o_scyc);
        end
      end
      if (c == 1) begin
        total++;
        if (o_scyc !== 1'b1 || o_saddr !== 32'h10) begin
          bad++;
          $display("FAIL single_grant scyc=%b addr=%h required 1/00000010", o_scyc, o_saddr);
        end
      end
      if (c == 2) begin
        total++;
        if (o_mack !== 3'b001) begin
          bad++;
          $display("FAIL single_ack mack=%b required 001", o_mack);
        end
      end
      tick();
    end
    release_all();
  endtask

  task automatic test_rr();
    int order[$];
    int gaps[$];
    int rem[NM];
    int exp_order[4];
    logic [NM-1:0] drop;
    int dly, wcnt, idle_run, prev, obs;
    logic done;
    exp_order = '{0, 1, 2, 0};
    rem = '{2, 1, 1};
    rst = 1'b1; tick(); rst = 1'b0;
    drop = '0; dly = $urandom_range(0, 2); wcnt = 0; idle_run = 0; prev = -1;
    for (int k = 0; k < NM; k++) begin
      load_master(k); mcyc[k] = 1'b1; mstb[k] = 1'b1;
    end
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < NM; k++) begin
        if (drop[k]) begin
          mcyc[k] = 1'b0; mstb[k] = 1'b0; drop[k] = 1'b0;
        end else if (!mcyc[k] && rem[k] > 0) begin
          load_master(k); mcyc[k] = 1'b1; mstb[k] = 1'b1;
        end
      end
      #1;
      sack  = o_sstb && (wcnt == dly);
      sdata = $urandom;
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL rr_model c=%0d act=%h exp=%h", c, act_vec, exp_vec);
      end
      if (o_scyc) begin
        obs = int'(o_saddr[31:24]);
        if (obs != prev) begin
          order.push_back(obs);
          if (prev >= 0) gaps.push_back(idle_run);
          prev = obs;
        end
        idle_run = 0;
      end else begin
        idle_run++;
      end
      if (o_mack != '0) begin
        for (int k = 0; k < NM; k++) begin
          if (o_mack[k]) begin drop[k] = 1'b1; rem[k]--; end
        end
        wcnt = 0; dly = $urandom_range(0, 2);
      end else if (o_sstb) begin
        wcnt++;
      end
      done = (rem[0] == 0) && (rem[1] == 0) && (rem[2] == 0) && (drop == '0);
      tick();
      if (done) break;
    end
    sack = 1'b0;
    total++;
    if (order.size() != 4) begin
      bad++;
      $display("FAIL rr_order_len got=%0d required 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (order[i] != exp_order[i]) begin
          bad++;
          $display("FAIL rr_order i=%0d got=%0d required %0d", i, order[i], exp_order[i]);
        end
      end
    end
    // CYC-low run between owners: the owner's release cycle plus one idle cycle.
    foreach (gaps[i]) begin
      total++;
      if (gaps[i] != 2) begin
        bad++;
        $display("FAIL rr_gap i=%0d got=%0d required 2", i, gaps[i]);
      end
    end
    release_all();
  endtask

  task automatic test_hold();
    load_master(1); load_master(2);
    mcyc[1] = 1'b1; mstb[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) begin mcyc[2] = 1'b1; mstb[2] = 1'b1; end
      sack = (c >= 1 && c <= 5);
      if (c == 6) begin mcyc[1] = 1'b0; mstb[1] = 1'b0; end
      sdata = $urandom;
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL hold_model c=%0d act=%h exp=%h", c, act_vec, exp_vec);
      end
      if (c >= 1 && c <= 5) begin
        total++;
        if (o_saddr !== maddr[1] || o_mack !== 3'b010) begin
          bad++;
          $display("FAIL hold_owner c=%0d addr=%h mack=%b required %h/010", c, o_saddr, o_mack, maddr[1]);
        end
      end
      if (c == 7) begin
        total++;
        if (o_scyc !== 1'b0) begin
          bad++;
          $display("FAIL hold_idle scyc=%b required 0", o_scyc);
        end
      end
      if (c == 8) begin
        total++;
        if (o_scyc !== 1'b1 || o_saddr !== maddr[2]) begin
          bad++;
          $display("FAIL hold_next scyc=%b addr=%h required 1/%h", o_scyc, o_saddr, maddr[2]);
        end
      end
      tick();
    end
    release_all();
  endtask

  task automatic test_timeout();
    int errs[$];
    int n;
    load_master(0);
    mcyc[0] = 1'b1; mstb[0] = 1'b1; sack = 1'b0; serr = 1'b0;
    n = 0;
    for (int c = 0; c < 12 && n < 9; c++) begin
      #1;
      if (o_sstb) n++;
      sack = (n == 9);
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL tmo_model n=%0d act=%h exp=%h", n, act_vec, exp_vec);
      end
      if (o_merr != '0) errs.push_back(n);
      total++;
      if (o_mack !== ((n == 9) ? 3'b001 : 3'b000)) begin
        bad++;
        $display("FAIL tmo_ack n=%0d mack=%b required %b", n, o_mack, (n == 9) ? 3'b001 : 3'b000);
      end
      tick();
    end
    total++;
    if (errs.size() != 2 || errs[0] != 4 || errs[1] != 8) begin
      bad++;
      $display("FAIL tmo_pulses count=%0d first=%0d required 2 pulses at 4,8",
               errs.size(), (errs.size() > 0) ? errs[0] : -1);
    end
    release_all();
  endtask

  task automatic test_serr();
    load_master(2);
    mcyc[2] = 1'b1; mstb[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      serr = (c == 1);
      if (c == 2) begin mcyc[2] = 1'b0; mstb[2] = 1'b0; end
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL serr_model c=%0d act=%h exp=%h", c, act_vec, exp_vec);
      end
      if (c == 1) begin
        total++;
        if (o_merr !== 3'b100 || o_mack !== 3'b000) begin
          bad++;
          $display("FAIL serr_route merr=%b mack=%b required 100/000", o_merr, o_mack);
        end
      end
      tick();
    end
    release_all();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < NM; k++) load_master(k);
    mcyc[1] = 1'b1; mstb[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rst = (c == 2);
      if (c == 3) begin mcyc = '1; mstb = '1; end
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL rmid_model c=%0d act=%h exp=%h", c, act_vec, exp_vec);
      end
      if (c == 3) begin
        total++;
        if ({o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel, o_mack, o_merr} !== '0) begin
          bad++;
          $display("FAIL rmid_drop act=%h required all zero", act_vec);
        end
      end
      if (c == 4) begin
        total++;
        if (o_scyc !== 1'b1 || o_saddr !== maddr[0]) begin
          bad++;
          $display("FAIL rmid_restart addr=%h required %h", o_saddr, maddr[0]);
        end
      end
      tick();
    end
    rst = 1'b0;
    release_all();
  endtask

  task automatic test_random();
    logic [NM-1:0] drop, reissue;
    drop = '0; reissue = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NM; k++) begin
        if (drop[k]) begin
          mcyc[k] = 1'b0; mstb[k] = 1'b0; drop[k] = 1'b0;
        end else if (!mcyc[k] && $urandom_range(0, 3) == 0) begin
          load_master(k); mcyc[k] = 1'b1; mstb[k] = 1'b1;
        end else if (reissue[k]) begin
          load_master(k);
        end
        reissue[k] = 1'b0;
      end
      #1;
      sack  = o_sstb && ($urandom_range(0, 1) == 1);
      serr  = o_sstb && !sack && ($urandom_range(0, 9) == 0);
      sdata = $urandom;
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL rand_model c=%0d act=%h exp=%h", c, act_vec, exp_vec);
      end
      for (int k = 0; k < NM; k++) begin
        if (o_mack[k] || o_merr[k]) begin
          if ($urandom_range(0, 1) == 1) drop[k] = 1'b1;
          else reissue[k] = 1'b1;
        end
      end
      tick();
    end
    release_all();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_hold();
    test_timeout();
    test_serr();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
